// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg
//   Shared types and helpers for the booth multiplier arbiter slice.
//   - state_t          : arbiter FSM states (IDLE, LOAD, RUN, RESP)
//   - WIDTH_DEFAULT    : default operand width
//   - TIMEOUT_DEFAULT  : default watchdog limit in RUN cycles
//   - rr_pick()        : round-robin search over up to MAX_REQ requesters
package booth_mult_pkg;

  localparam int WIDTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  // Upper bound on the requester count; the picker works on vectors of
  // this size and the caller zero-extends its own narrower vectors.
  localparam int MAX_REQ  = 8;
  localparam int RR_PTR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic                found;
    logic [RR_PTR_W-1:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr+1, wrapping modulo n.
  // The search visits ptr+1 .. ptr+n so the last-granted requester is
  // considered last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                       input logic [RR_PTR_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      c = (32'(ptr) + k) % n;
      if (k <= n && !r.found && valid[c[RR_PTR_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[RR_PTR_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_grant.sv
// rr_grant
//   Combinational round-robin picker.
//   valid  : per-requester request vector
//   rr_ptr : index of the most recently granted requester
//   grant  : one-hot grant (all zero when nothing is valid)
//   idx    : binary index of the granted requester
//   found  : at least one requester is valid
module rr_grant
  import booth_mult_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             found
);

  logic [MAX_REQ-1:0]  valid_ext;
  logic [RR_PTR_W-1:0] ptr_ext;
  rr_pick_t            pick;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = valid;
    ptr_ext                = '0;
    ptr_ext[IDW-1:0]       = rr_ptr;
    pick                   = rr_pick(valid_ext, ptr_ext, N_REQ);
    found                  = pick.found;
    idx                    = pick.idx[IDW-1:0];
    grant                  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = pick.found && (pick.idx == RR_PTR_W'(i));
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one booth_multiplier between N_REQ requesters. Grants are
//   round-robin; each grant loads the multiplier for one cycle, runs it until
//   mul_done (or the watchdog expires) and returns one tagged response.
//   Ports:
//     clk, reset_n                  clock, async active-low reset
//     req_valid/req_a/req_b         per-requester request and operands
//     req_ready                     one-hot accept pulse
//     rsp_valid/rsp_ready           response handshake
//     rsp_id/rsp_product/rsp_err    response payload (err => product 0)
//     mul_load/mul_multiplicand/mul_multiplier   drive the multiplier
//     mul_product/mul_done          returned by the multiplier
//   All outputs are registers.
module booth_mult_arbiter
  import booth_mult_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]     rsp_product,
  output logic                   rsp_err,
  output logic                   mul_load,
  output logic [WIDTH-1:0]       mul_multiplicand,
  output logic [WIDTH-1:0]       mul_multiplier,
  input  logic [2*WIDTH-1:0]     mul_product,
  input  logic                   mul_done
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WDW-1:0]   wd_cnt;

  logic [N_REQ-1:0] gnt_onehot;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;

  rr_grant #(.N_REQ(N_REQ)) u_rr_grant (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (gnt_onehot),
    .idx    (gnt_idx),
    .found  (gnt_found)
  );

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register, datapath included, is reset so an operation
      // cut short by reset leaves no stale response or operands behind.
      state            <= IDLE;
      rr_ptr           <= IDW'(N_REQ - 1);
      id_q             <= '0;
      wd_cnt           <= '0;
      req_ready        <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_product      <= '0;
      rsp_err          <= 1'b0;
      mul_load         <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      // Accept is a single-cycle pulse.
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready        <= gnt_onehot;
            mul_multiplicand <= req_a[gnt_idx*WIDTH +: WIDTH];
            mul_multiplier   <= req_b[gnt_idx*WIDTH +: WIDTH];
            id_q             <= gnt_idx;
            rr_ptr           <= gnt_idx;
            mul_load         <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          // The load pulse has cleared the multiplier; any done seen here
          // belongs to the previous operation and is ignored.
          mul_load <= 1'b0;
          wd_cnt   <= '0;
          state    <= RUN;
        end
        RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_id      <= id_q;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            rsp_id      <= id_q;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter
//   Directed bench for booth_mult_arbiter (N_REQ=2, WIDTH=4, TIMEOUT=16).
//   A behavioural multiplier stub raises a sticky done a programmable number
//   of RUN cycles after the load pulse (0 = never) and returns a*b.
module tb_booth_mult_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [7:0] req_a, req_b;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_product;
  logic       rsp_err;
  logic       mul_load;
  logic [3:0] mul_multiplicand, mul_multiplier;
  logic [7:0] mul_product;
  logic       mul_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.N_REQ(2), .WIDTH(4), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product),
    .rsp_err          (rsp_err),
    .mul_load         (mul_load),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_done         (mul_done)
  );

  // ---------------- multiplier stub ----------------
  int         done_at = 5;
  int         cyc = 0;
  logic [3:0] stub_a = '0, stub_b = '0;
  logic signed [7:0] ext_a, ext_b;

  always @(posedge clk) begin
    if (mul_load) begin
      stub_a <= mul_multiplicand;
      stub_b <= mul_multiplier;
      cyc    <= 1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  always_comb begin
    ext_a       = {{4{stub_a[3]}}, stub_a};
    ext_b       = {{4{stub_b[3]}}, stub_b};
    mul_done    = (done_at != 0) && (cyc >= done_at);
    mul_product = mul_done ? 8'(ext_a * ext_b) : 8'h5A;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    logic found = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({name, "_ready_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic wait_rsp(input string name, output int lat);
    logic found = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        lat   = n;
        break;
      end
    end
    if (!found) check({name, "_rsp_timeout"}, 32'(found), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0, a1, b1;
    int         done_at;
    logic [1:0] exp_ready;
    logic [7:0] exp_prod;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input int i);
    vec_t  v;
    int    lat;
    string nm;
    logic  gid;
    v   = vecs[i];
    nm  = $sformatf("v%0d", i);
    gid = v.exp_ready[1];
    done_at   = v.done_at;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    rsp_ready = 1'b1;
    req_valid = v.valid;
    wait_ready(nm);
    check({nm, "_req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    check({nm, "_mul_load"},  32'(mul_load), 32'd1);
    check({nm, "_mul_a"},     32'(mul_multiplicand), 32'(gid ? v.a1 : v.a0));
    check({nm, "_mul_b"},     32'(mul_multiplier),   32'(gid ? v.b1 : v.b0));
    req_valid = 2'b00;
    @(negedge clk);
    check({nm, "_load_drop"}, 32'(mul_load), 32'd0);
    wait_rsp(nm, lat);
    check({nm, "_latency"}, 32'(lat + 1), 32'(v.exp_lat));
    check({nm, "_rsp_id"},  32'(rsp_id), 32'(gid));
    check({nm, "_product"}, 32'(rsp_product), 32'(v.exp_prod));
    check({nm, "_err"},     32'(rsp_err), 32'(v.exp_err));
    @(negedge clk);
    check({nm, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   lat;
    logic saw_rsp;

    //                valid  a0     b0     a1     b1    done exp_rdy prod   err lat
    vecs[0] = '{2'b01, 4'd3,  4'hE,  4'd0,  4'd0,  5,  2'b01, 8'hFA, 1'b0, 6};  // 3*-2
    vecs[1] = '{2'b10, 4'd0,  4'd0,  4'h8,  4'h8,  5,  2'b10, 8'h40, 1'b0, 6};  // -8*-8
    vecs[2] = '{2'b11, 4'd7,  4'h8,  4'd1,  4'd1,  5,  2'b01, 8'hC8, 1'b0, 6};  // 7*-8
    vecs[3] = '{2'b11, 4'd1,  4'd1,  4'd0,  4'd5,  5,  2'b10, 8'h00, 1'b0, 6};  // 0*5
    vecs[4] = '{2'b01, 4'hF,  4'hF,  4'd0,  4'd0,  3,  2'b01, 8'h01, 1'b0, 4};  // -1*-1
    vecs[5] = '{2'b10, 4'd0,  4'd0,  4'd7,  4'd7,  1,  2'b10, 8'h31, 1'b0, 2};  // 7*7, done at once
    vecs[6] = '{2'b01, 4'd2,  4'd3,  4'd0,  4'd0,  0,  2'b01, 8'h00, 1'b1, 17}; // never done
    vecs[7] = '{2'b01, 4'd2,  4'd3,  4'd0,  4'd0,  16, 2'b01, 8'h06, 1'b0, 17}; // done on last cycle
    vecs[8] = '{2'b01, 4'd2,  4'd3,  4'd0,  4'd0,  17, 2'b01, 8'h00, 1'b1, 17}; // done one too late
    vecs[9] = '{2'b10, 4'd0,  4'd0,  4'h8,  4'd7,  5,  2'b10, 8'hC8, 1'b0, 6};  // -8*7

    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_mul_load",  32'(mul_load), 32'd0);
    check("rst_rsp_id",    32'(rsp_id), 32'd0);
    check("rst_product",   32'(rsp_product), 32'd0);
    check("rst_mul_a",     32'(mul_multiplicand), 32'd0);
    check("rst_mul_b",     32'(mul_multiplier), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // ---- backpressure: response held 10 cycles, accepted on the 11th ----
    done_at   = 5;
    req_a     = {4'hD, 4'd3};
    req_b     = {4'd5, 4'd3};
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    wait_ready("bp");
    check("bp_req_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b10;
    wait_rsp("bp", lat);
    for (int i = 1; i <= 11; i++) begin
      check($sformatf("bp_valid_%0d", i),   32'(rsp_valid), 32'd1);
      check($sformatf("bp_product_%0d", i), 32'(rsp_product), 32'h09);
      check($sformatf("bp_id_%0d", i),      32'(rsp_id), 32'd0);
      check($sformatf("bp_ready_%0d", i),   32'(req_ready), 32'd0);
      check($sformatf("bp_load_%0d", i),    32'(mul_load), 32'd0);
      if (i == 11) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    check("bp_no_early_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    wait_rsp("bp2", lat);
    check("bp2_product", 32'(rsp_product), 32'hF1);
    check("bp2_id",      32'(rsp_id), 32'd1);
    @(negedge clk);

    // ---- reset in the middle of RUN ----
    done_at   = 5;
    req_a     = {4'hC, 4'd3};
    req_b     = {4'hC, 4'd3};
    req_valid = 2'b01;
    wait_ready("mr");
    check("mr_req_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mr_rst_load",    32'(mul_load), 32'd0);
    check("mr_rst_valid",   32'(rsp_valid), 32'd0);
    check("mr_rst_product", 32'(rsp_product), 32'd0);
    check("mr_rst_mul_a",   32'(mul_multiplicand), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid | (req_ready != 2'b00);
    end
    check("mr_no_response", 32'(saw_rsp), 32'd0);

    // ---- round robin with both requesters held valid; 0 first after reset ----
    req_a     = {4'hC, 4'd2};
    req_b     = {4'hC, 4'd3};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready($sformatf("rr%0d", k));
      check($sformatf("rr%0d_grant", k), 32'(req_ready), (k % 2) ? 32'h2 : 32'h1);
      wait_rsp($sformatf("rr%0d", k), lat);
      check($sformatf("rr%0d_id", k),      32'(rsp_id), 32'(k % 2));
      check($sformatf("rr%0d_product", k), 32'(rsp_product), (k % 2) ? 32'h10 : 32'h06);
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
